ddr_axi_burst_master: RTL
=========================

Name: ddr_axi_burst_master

Overview:
- Synthesizable AXI-style burst initiator that drives the DDR slave port (WR_ADDR/WR_DATA/WR_BACK and RD_ADDR/RD_DATA channels, 32-bit data, 4-bit ID).
- Accepts one command at a time (address, length, direction, ID). For writes, it streams beats from a local write-data stream. For reads, it delivers beats to a local read-data stream.
- Sits between user logic (test-pattern/DMA engines) and the DDR controller.
- Signals completion with the response code and a protocol-error flag.

Parameters:
- ID_W, 4, AXI ID width.
- DATA_W, 32, data width; STRB width = DATA_W/8.

Ports:
- DDR_MASTER_CLK  in  1  sole clock.
- DDR_MASTER_RST  in  1  synchronous, active-high reset.
- CMD_VALID/CMD_READY  in/out  1/1  command handshake.
- CMD_WRITE  in  1  1=write burst, 0=read burst.
- CMD_ADDR  in  32  start address.
- CMD_LEN  in  8  beats-1.
- CMD_ID  in  ID_W  transaction ID.
- WDATA_IN, WDATA_IN_VALID / WDATA_IN_READY  in/out  DATA_W,1/1  user write stream.
- RDATA_OUT, RDATA_OUT_VALID, RDATA_OUT_LAST / RDATA_OUT_READY  out/in  DATA_W,1,1/1  user read stream.
- DONE, DONE_RESP, DONE_ERR  out  1,2,1  completion pulse, response code, protocol error.
- DDR_MASTER_WR_ADDR_ID/_ADDR/_LEN/_BURST/_VALID  out  ID_W/32/8/2/1.
- DDR_MASTER_WR_ADDR_READY  in  1.
- DDR_MASTER_WR_DATA/_STRB/_LAST/_VALID  out  DATA_W/DATA_W/8/1/1.
- DDR_MASTER_WR_DATA_READY  in  1.
- DDR_MASTER_WR_BACK_ID/_RESP/_VALID  in  ID_W/2/1.
- DDR_MASTER_WR_BACK_READY  out  1.
- DDR_MASTER_RD_ADDR_ID/_ADDR/_LEN/_BURST/_VALID  out  ID_W/32/8/2/1.
- DDR_MASTER_RD_ADDR_READY  in  1.
- DDR_MASTER_RD_BACK_ID/_DATA/_DATA_RESP/_DATA_LAST/_DATA_VALID  in  ID_W/DATA_W/2/1/1.
- DDR_MASTER_RD_DATA_READY  out  1.

Behaviour:
- Reset: state=IDLE. All VALID, READY, DONE, DONE_ERR, LAST outputs are 0. DONE_RESP=0; address/ID/LEN registers are 0; beat counter is 0.
- Constant outputs: BURST=2'b01 (INCR); STRB all ones.
- States: IDLE, WADDR, WDATA, WRESP, RADDR, RDATA, FIN.
- IDLE:
  - CMD_READY=1, decoded from the registered state.
  - On handshake, latch ADDR/LEN/ID and clear the beat counter.
  - Next state is WADDR if CMD_WRITE, else RADDR.
  - The ADDR_VALID rises on the cycle after the command handshake.
- WADDR/RADDR:
  - ADDR_VALID=1 with latched fields; fields are held stable until READY.
  - On handshake, go to WDATA or RDATA.
- WDATA:
  - WR_DATA_VALID=WDATA_IN_VALID; WDATA_IN_READY=WR_DATA_READY; WR_DATA=WDATA_IN (combinational pass-through, no bubble).
  - WR_DATA_LAST=(beat==LEN).
  - Each handshake increments beat; the handshake with LAST goes to WRESP.
  - LEN=0 gives a single beat with LAST asserted.
- WRESP:
  - WR_BACK_READY=1.
  - On VALID, capture RESP. DONE_ERR=1 if BACK_ID≠latched ID.
  - Go to FIN.
- RDATA:
  - RD_DATA_READY=RDATA_OUT_READY; RDATA_OUT_VALID=RD_DATA_VALID; RDATA_OUT=RD_DATA (pass-through).
  - RDATA_OUT_LAST=(beat==LEN), generated locally.
  - Each handshake increments beat and ORs RESP into a sticky response (worst-case OR).
  - Flag an error if BACK_ID≠ID, or if slave LAST disagrees with (beat==LEN).
  - Leave on the handshake where beat==LEN, regardless of slave LAST.
- FIN:
  - DONE=1 for exactly one cycle, with DONE_RESP and DONE_ERR valid in the same cycle. Then IDLE.
  - DONE_RESP/DONE_ERR hold until the next command is accepted.
- Beat counter: 8 bits, never wraps (max 255 = LEN 255, 256 beats).
- Exactly one outstanding transaction; CMD_READY=0 in all non-IDLE states.
- Reset mid-burst: immediate return to IDLE with all outputs at their reset values. The slave side is expected to be reset in the same domain.
- Backpressure stalls: stalls in WDATA (either side) or RDATA hold the state and beat indefinitely; no timeout.

Optional Feature:
- DDR_MASTER_STATS_EN defined: adds outputs STAT_WR_CNT[15:0], STAT_RD_CNT[15:0] and STAT_ERR_CNT[15:0].
  - STAT_WR_CNT / STAT_RD_CNT increment in FIN per completed write/read.
  - STAT_ERR_CNT increments when DONE_ERR=1 or DONE_RESP≠0.
  - Counters saturate at 16'hFFFF and clear on reset.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Write ADDR=0x100, LEN=3, ID=5, data 0xA0..0xA3, slave always ready:
  - WR_ADDR_VALID one cycle after the command.
  - 4 beats with LAST on 0xA3.
  - DONE pulse, DONE_RESP=0, DONE_ERR=0.
- Read back ADDR=0x100, LEN=3, ID=6:
  - RDATA_OUT 0xA0..0xA3.
  - RDATA_OUT_LAST on the 4th beat; RD_ADDR_LEN=3; DONE_ERR=0.
- LEN=0 write and read:
  - Single beat with LAST on the first beat in both directions.
  - DONE asserts exactly once per command.
- Backpressure: toggle WDATA_IN_VALID and WR_DATA_READY randomly (LEN=7), then RDATA_OUT_READY (LEN=7):
  - Exactly 8 beats each way, data in order, no duplicates.
- Errors:
  - Slave returns WR_BACK_ID=2 for ID=5 → DONE_ERR=1.
  - Read beat 2 with RESP=2'b10 → DONE_RESP=2'b10.
  - Slave LAST early at beat 1 of LEN=3 → DONE_ERR=1.
- Reset asserted in the middle of WDATA (beat 2 of LEN=7):
  - Next cycle all VALIDs are 0 and CMD_READY=1 after release.
  - A new command then completes normally; with DDR_MASTER_STATS_EN, counters read 0 after reset.

Source files
------------

// File: rtl/ddr_axi_burst_master.sv
// ddr_axi_burst_master: single-outstanding AXI-style burst initiator for the
// DDR slave port. Write beats stream straight from WDATA_IN and read beats
// stream straight to RDATA_OUT. Both paths are combinational, so no bubbles
// are added. Completion is reported with a one-cycle DONE pulse.
// Optional feature macro: DDR_MASTER_STATS_EN. It adds the saturating
// STAT_WR_CNT, STAT_RD_CNT and STAT_ERR_CNT counters.
module ddr_axi_burst_master #(
  parameter int ID_W   = 4,
  parameter int DATA_W = 32
) (
  input  logic                DDR_MASTER_CLK,
  input  logic                DDR_MASTER_RST,
  input  logic                CMD_VALID,
  output logic                CMD_READY,
  input  logic                CMD_WRITE,
  input  logic [31:0]         CMD_ADDR,
  input  logic [7:0]          CMD_LEN,
  input  logic [ID_W-1:0]     CMD_ID,
  input  logic [DATA_W-1:0]   WDATA_IN,
  input  logic                WDATA_IN_VALID,
  output logic                WDATA_IN_READY,
  output logic [DATA_W-1:0]   RDATA_OUT,
  output logic                RDATA_OUT_VALID,
  output logic                RDATA_OUT_LAST,
  input  logic                RDATA_OUT_READY,
  output logic                DONE,
  output logic [1:0]          DONE_RESP,
  output logic                DONE_ERR,
  output logic [ID_W-1:0]     DDR_MASTER_WR_ADDR_ID,
  output logic [31:0]         DDR_MASTER_WR_ADDR_ADDR,
  output logic [7:0]          DDR_MASTER_WR_ADDR_LEN,
  output logic [1:0]          DDR_MASTER_WR_ADDR_BURST,
  output logic                DDR_MASTER_WR_ADDR_VALID,
  input  logic                DDR_MASTER_WR_ADDR_READY,
  output logic [DATA_W-1:0]   DDR_MASTER_WR_DATA,
  output logic [DATA_W/8-1:0] DDR_MASTER_WR_DATA_STRB,
  output logic                DDR_MASTER_WR_DATA_LAST,
  output logic                DDR_MASTER_WR_DATA_VALID,
  input  logic                DDR_MASTER_WR_DATA_READY,
  input  logic [ID_W-1:0]     DDR_MASTER_WR_BACK_ID,
  input  logic [1:0]          DDR_MASTER_WR_BACK_RESP,
  input  logic                DDR_MASTER_WR_BACK_VALID,
  output logic                DDR_MASTER_WR_BACK_READY,
  output logic [ID_W-1:0]     DDR_MASTER_RD_ADDR_ID,
  output logic [31:0]         DDR_MASTER_RD_ADDR_ADDR,
  output logic [7:0]          DDR_MASTER_RD_ADDR_LEN,
  output logic [1:0]          DDR_MASTER_RD_ADDR_BURST,
  output logic                DDR_MASTER_RD_ADDR_VALID,
  input  logic                DDR_MASTER_RD_ADDR_READY,
  input  logic [ID_W-1:0]     DDR_MASTER_RD_BACK_ID,
  input  logic [DATA_W-1:0]   DDR_MASTER_RD_BACK_DATA,
  input  logic [1:0]          DDR_MASTER_RD_BACK_DATA_RESP,
  input  logic                DDR_MASTER_RD_BACK_DATA_LAST,
  input  logic                DDR_MASTER_RD_BACK_DATA_VALID,
  output logic                DDR_MASTER_RD_DATA_READY
`ifdef DDR_MASTER_STATS_EN
  ,
  output logic [15:0]         STAT_WR_CNT,
  output logic [15:0]         STAT_RD_CNT,
  output logic [15:0]         STAT_ERR_CNT
`endif
);

  typedef enum logic [2:0] {IDLE, WADDR, WDATA, WRESP, RADDR, RDATA, FIN} state_t;

  state_t            state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [7:0]        beat_q, beat_d;
  logic [1:0]        resp_q, resp_d;
  logic              err_q, err_d;
  logic              wr_q, wr_d;
  logic              last_beat;

  assign last_beat = (beat_q == len_q);

  // Latched command fields drive both address channels.
  assign DDR_MASTER_WR_ADDR_ID    = id_q;
  assign DDR_MASTER_WR_ADDR_ADDR  = addr_q;
  assign DDR_MASTER_WR_ADDR_LEN   = len_q;
  assign DDR_MASTER_WR_ADDR_BURST = 2'b01;
  assign DDR_MASTER_RD_ADDR_ID    = id_q;
  assign DDR_MASTER_RD_ADDR_ADDR  = addr_q;
  assign DDR_MASTER_RD_ADDR_LEN   = len_q;
  assign DDR_MASTER_RD_ADDR_BURST = 2'b01;
  assign DDR_MASTER_WR_DATA       = WDATA_IN;
  assign DDR_MASTER_WR_DATA_STRB  = '1;
  assign RDATA_OUT                = DDR_MASTER_RD_BACK_DATA;
  assign DONE_RESP                = resp_q;
  assign DONE_ERR                 = err_q;

  // Next-state, handshake decode and command/response bookkeeping.
  always_comb begin
    state_d                  = state_q;
    addr_d                   = addr_q;
    len_d                    = len_q;
    id_d                     = id_q;
    beat_d                   = beat_q;
    resp_d                   = resp_q;
    err_d                    = err_q;
    wr_d                     = wr_q;
    CMD_READY                = 1'b0;
    WDATA_IN_READY           = 1'b0;
    RDATA_OUT_VALID          = 1'b0;
    RDATA_OUT_LAST           = 1'b0;
    DONE                     = 1'b0;
    DDR_MASTER_WR_ADDR_VALID = 1'b0;
    DDR_MASTER_WR_DATA_VALID = 1'b0;
    DDR_MASTER_WR_DATA_LAST  = 1'b0;
    DDR_MASTER_WR_BACK_READY = 1'b0;
    DDR_MASTER_RD_ADDR_VALID = 1'b0;
    DDR_MASTER_RD_DATA_READY = 1'b0;
    case (state_q)
      IDLE: begin
        // Hold READY low while reset is held, so no command is acknowledged then.
        CMD_READY = !DDR_MASTER_RST;
        if (CMD_VALID) begin
          addr_d  = CMD_ADDR;
          len_d   = CMD_LEN;
          id_d    = CMD_ID;
          beat_d  = 8'd0;
          resp_d  = 2'b00;
          err_d   = 1'b0;
          wr_d    = CMD_WRITE;
          state_d = CMD_WRITE ? WADDR : RADDR;
        end
      end
      WADDR: begin
        DDR_MASTER_WR_ADDR_VALID = 1'b1;
        if (DDR_MASTER_WR_ADDR_READY) state_d = WDATA;
      end
      WDATA: begin
        DDR_MASTER_WR_DATA_VALID = WDATA_IN_VALID;
        WDATA_IN_READY           = DDR_MASTER_WR_DATA_READY;
        DDR_MASTER_WR_DATA_LAST  = last_beat;
        if (WDATA_IN_VALID && DDR_MASTER_WR_DATA_READY) begin
          if (last_beat) state_d = WRESP;
          else           beat_d  = beat_q + 8'd1;
        end
      end
      WRESP: begin
        DDR_MASTER_WR_BACK_READY = 1'b1;
        if (DDR_MASTER_WR_BACK_VALID) begin
          resp_d  = DDR_MASTER_WR_BACK_RESP;
          err_d   = (DDR_MASTER_WR_BACK_ID != id_q);
          state_d = FIN;
        end
      end
      RADDR: begin
        DDR_MASTER_RD_ADDR_VALID = 1'b1;
        if (DDR_MASTER_RD_ADDR_READY) state_d = RDATA;
      end
      RDATA: begin
        DDR_MASTER_RD_DATA_READY = RDATA_OUT_READY;
        RDATA_OUT_VALID          = DDR_MASTER_RD_BACK_DATA_VALID;
        RDATA_OUT_LAST           = last_beat;
        if (DDR_MASTER_RD_BACK_DATA_VALID && RDATA_OUT_READY) begin
          // The response is sticky (worst case wins). The local beat count,
          // not the slave's LAST, decides where the burst ends.
          resp_d = resp_q | DDR_MASTER_RD_BACK_DATA_RESP;
          err_d  = err_q | (DDR_MASTER_RD_BACK_ID != id_q)
                         | (DDR_MASTER_RD_BACK_DATA_LAST != last_beat);
          if (last_beat) state_d = FIN;
          else           beat_d  = beat_q + 8'd1;
        end
      end
      FIN: begin
        DONE    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge DDR_MASTER_CLK) begin
    if (DDR_MASTER_RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      id_q    <= '0;
      beat_q  <= '0;
      resp_q  <= '0;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      id_q    <= id_d;
      beat_q  <= beat_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
      wr_q    <= wr_d;
    end
  end

`ifdef DDR_MASTER_STATS_EN
  logic [15:0] wr_cnt_q, rd_cnt_q, err_cnt_q;
  assign STAT_WR_CNT  = wr_cnt_q;
  assign STAT_RD_CNT  = rd_cnt_q;
  assign STAT_ERR_CNT = err_cnt_q;

  // Saturating completion counters, which are updated on the FIN cycle.
  always_ff @(posedge DDR_MASTER_CLK) begin
    if (DDR_MASTER_RST) begin
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else if (state_q == FIN) begin
      if (wr_q && wr_cnt_q != 16'hFFFF)   wr_cnt_q <= wr_cnt_q + 16'd1;
      if (!wr_q && rd_cnt_q != 16'hFFFF)  rd_cnt_q <= rd_cnt_q + 16'd1;
      if ((err_q || resp_q != 2'b00) && err_cnt_q != 16'hFFFF)
        err_cnt_q <= err_cnt_q + 16'd1;
    end
  end
`else
  // Write/read kind only feeds the statistics counters.
  logic unused_wr;
  assign unused_wr = wr_q;
`endif

endmodule
